// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, X/Y scan counters, sync/blank decode and a
// pixel-tick delay line that keeps sync/blank aligned with painter RGB. Optional macro: VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter int   SYNC_DLY = 1,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        pix_tick,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } decode_t;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             vga_clk_q, vga_clk_d;
    logic             en_q;
    logic             line_end;
    logic             frame_end;
    decode_t          raw;
    decode_t          dly;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        line_end    = (x_q == H_LAST);
        frame_end   = line_end && (y_q == V_LAST);
        pix_tick    = en && (div_cnt_q == DIV_LAST);
        frame_start = pix_tick && frame_end;

        if (en) begin
            div_cnt_d = pix_tick ? '0 : div_cnt_q + 1'b1;
        end

        if (pix_tick) begin
            x_d = line_end ? 10'd0 : x_q + 10'd1;
            if (line_end) begin
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end
        end

        // Register the divider's comparison so the DAC clock leaves a flop, glitch-free.
        vga_clk_d = (div_cnt_d >= DIV_HALF);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            vga_clk_q <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vga_clk_q <= vga_clk_d;
            en_q      <= en;
        end
    end

    always_comb begin
        raw        = '0;
        raw.active = (x_q < H_ACT) && (y_q < V_ACT);
        raw.hs     = (x_q >= HS_BEG) && (x_q < HS_END);
        raw.vs     = (y_q >= VS_BEG) && (y_q < VS_END);
    end

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign dly = raw;
        end else begin : g_dly
            decode_t stage_q [SYNC_DLY];

            // NOTE: this small shift register is reset (unlike a RAM) because its contents
            // reach the sync pins directly; stale stages would emit a bogus pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        stage_q[i] <= '0;
                    end
                end else if (pix_tick) begin
                    stage_q[0] <= raw;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dly = stage_q[SYNC_DLY-1];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Blanking is forced off one clk after en drops, independent of the held delay line.
    assign X       = x_q;
    assign Y       = y_q;
    assign vga_clk = vga_clk_q;
    assign hsync   = dly.hs ? HS_POL : ~HS_POL;
    assign vsync   = dly.vs ? VS_POL : ~VS_POL;
    assign sync_n  = ~(dly.hs | dly.vs);
    assign blank_n = dly.active && en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: directed vector table on the default 640x480 timing,
// plus hand-written sequences (line counts, enable gap, async reset) and a tiny-raster instance.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n, en;
    logic rst_s_n, en_s;

    logic [9:0] x_m, y_m;
    logic pix_tick_m, vga_clk_m, hsync_m, vsync_m, blank_n_m, sync_n_m, frame_start_m;
    logic [9:0] x_s, y_s;
    logic pix_tick_s, vga_clk_s, hsync_s, vsync_s, blank_n_s, sync_n_s, frame_start_s;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_m, frame_cnt_s;
`endif

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .X           (x_m),
        .Y           (y_m),
        .pix_tick    (pix_tick_m),
        .vga_clk     (vga_clk_m),
        .hsync       (hsync_m),
        .vsync       (vsync_m),
        .blank_n     (blank_n_m),
        .sync_n      (sync_n_m),
        .frame_start (frame_start_m)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_m)
`endif
    );

    // Tiny raster: 8x7 totals, CLK_DIV=4, two-tick delay, positive sync polarity.
    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .CLK_DIV  (4), .SYNC_DLY (2), .HS_POL (1'b1), .VS_POL (1'b1)
    ) u_small (
        .clk         (clk),
        .rst_n       (rst_s_n),
        .en          (en_s),
        .X           (x_s),
        .Y           (y_s),
        .pix_tick    (pix_tick_s),
        .vga_clk     (vga_clk_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .blank_n     (blank_n_s),
        .sync_n      (sync_n_s),
        .frame_start (frame_start_s)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt_s)
`endif
    );

    // flags = {pix_tick, vga_clk, hsync, vsync, blank_n, sync_n, frame_start}
    typedef struct {
        int         adv;
        logic [9:0] x;
        logic [9:0] y;
        logic [6:0] flags;
    } vec_t;

    localparam logic [6:0] RST_FLAGS = 7'b0011010;

    vec_t vecs [15];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [26:0] snap_m();
        return {x_m, y_m, pix_tick_m, vga_clk_m, hsync_m, vsync_m, blank_n_m, sync_n_m, frame_start_m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_lo, bn_hi, guard;
        int fs_cnt, first_fs, last_fs, fs_period;
        int hs_hi_s, vs_hi_s, bn_hi_s, sn_lo_s, vc_hi_s;

        // Cumulative clk count after reset release shown per row.
        vecs[0]  = '{adv: 1,    x: 10'd0,   y: 10'd0, flags: 7'b1111010}; // k=1
        vecs[1]  = '{adv: 1,    x: 10'd1,   y: 10'd0, flags: 7'b0011110}; // k=2 first tick
        vecs[2]  = '{adv: 1,    x: 10'd1,   y: 10'd0, flags: 7'b1111110}; // k=3
        vecs[3]  = '{adv: 1277, x: 10'd640, y: 10'd0, flags: 7'b0011110}; // k=1280
        vecs[4]  = '{adv: 2,    x: 10'd641, y: 10'd0, flags: 7'b0011010}; // blank falls
        vecs[5]  = '{adv: 29,   x: 10'd655, y: 10'd0, flags: 7'b1111010}; // k=1311
        vecs[6]  = '{adv: 1,    x: 10'd656, y: 10'd0, flags: 7'b0011010}; // k=1312
        vecs[7]  = '{adv: 2,    x: 10'd657, y: 10'd0, flags: 7'b0001000}; // hsync starts
        vecs[8]  = '{adv: 190,  x: 10'd752, y: 10'd0, flags: 7'b0001000}; // last low tick
        vecs[9]  = '{adv: 2,    x: 10'd753, y: 10'd0, flags: 7'b0011010}; // hsync ends
        vecs[10] = '{adv: 92,   x: 10'd799, y: 10'd0, flags: 7'b0011010}; // k=1598
        vecs[11] = '{adv: 1,    x: 10'd799, y: 10'd0, flags: 7'b1111010}; // k=1599
        vecs[12] = '{adv: 1,    x: 10'd0,   y: 10'd1, flags: 7'b0011010}; // line wrap
        vecs[13] = '{adv: 2,    x: 10'd1,   y: 10'd1, flags: 7'b0011110}; // k=1602
        vecs[14] = '{adv: 1,    x: 10'd1,   y: 10'd1, flags: 7'b1111110}; // k=1603

        rst_n   = 1'b0;
        en      = 1'b1;
        rst_s_n = 1'b0;
        en_s    = 1'b1;
        repeat (3) step();
        check("reset_state", snap_m(), {10'd0, 10'd0, RST_FLAGS});
        check("small_reset_pol", {hsync_s, vsync_s, blank_n_s, sync_n_s}, 4'b0001);
`ifdef VGA_FRAME_CNT_EN
        check("reset_frame_cnt", frame_cnt_m, 16'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            repeat (vecs[i].adv) step();
            check($sformatf("vec%0d", i), snap_m(), {vecs[i].x, vecs[i].y, vecs[i].flags});
        end

        // One full line (line 1): hsync low 96 ticks, blank_n high 640 ticks, 2 clks each.
        hs_lo = 0;
        bn_hi = 0;
        for (int k = 0; k < 1600; k++) begin
            step();
            if (!hsync_m)  hs_lo++;
            if (blank_n_m) bn_hi++;
        end
        check("hsync_low_clks", hs_lo, 192);
        check("blank_high_clks", bn_hi, 1280);
        check("line2_y", y_m, 10'd2);

        // Enable gap starting just after X becomes 300.
        guard = 0;
        while (!(x_m == 10'd300 && !pix_tick_m) && guard < 2000) begin
            step();
            guard++;
        end
        check("reach_x300", x_m, 10'd300);
        check("blank_before_gap", blank_n_m, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("gap_clk%0d", k), {x_m, blank_n_m, pix_tick_m}, {10'd300, 2'b00});
        end
        en = 1'b1;
        step();
        check("resume_1clk", {x_m, pix_tick_m}, {10'd300, 1'b1});
        step();
        check("resume_2clk", x_m, 10'd301);

        // Asynchronous reset mid-line while hsync is asserted and pix_tick is high.
        guard = 0;
        while (!(x_m == 10'd700 && pix_tick_m) && guard < 2000) begin
            step();
            guard++;
        end
        check("pre_reset", {x_m, pix_tick_m, vga_clk_m, hsync_m, sync_n_m}, {10'd700, 4'b1100});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", snap_m(), {10'd0, 10'd0, RST_FLAGS});
`ifdef VGA_FRAME_CNT_EN
        check("async_reset_frame_cnt", frame_cnt_m, 16'd0);
`endif

        // Tiny raster: two frames (56 ticks = 224 clks each); counts taken over clks 224..447.
        step();
        rst_s_n  = 1'b1;
        fs_cnt   = 0;
        first_fs = -1;
        last_fs  = 0;
        fs_period = 0;
        hs_hi_s  = 0;
        vs_hi_s  = 0;
        bn_hi_s  = 0;
        sn_lo_s  = 0;
        vc_hi_s  = 0;
        for (int k = 1; k <= 448; k++) begin
            step();
            if (frame_start_s) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = k;
                else              fs_period = k - last_fs;
                last_fs = k;
            end
            if (k >= 224 && k <= 447) begin
                if (hsync_s)   hs_hi_s++;
                if (vsync_s)   vs_hi_s++;
                if (blank_n_s) bn_hi_s++;
                if (!sync_n_s) sn_lo_s++;
                if (vga_clk_s) vc_hi_s++;
            end
`ifdef VGA_FRAME_CNT_EN
            if (k == 224) check("frame_cnt_after_frame", frame_cnt_s, 16'd1);
`endif
        end
        check("small_fs_first", first_fs, 223);
        check("small_fs_count", fs_cnt, 2);
        check("small_fs_period", fs_period, 224);
        check("small_hsync_high", hs_hi_s, 56);
        check("small_vsync_high", vs_hi_s, 64);
        check("small_blank_high", bn_hi_s, 48);
        check("small_sync_n_low", sn_lo_s, 104);
        check("small_vga_clk_high", vc_hi_s, 112);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
